// File: rtl/maxpool_controller_if.sv
// Handshake and RAM-port bundle for maxpool_controller.
// master: the pooling sequencer; slave: top-level controller plus both RAMs.
interface maxpool_controller_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RD_ADDR_W = 12,
    parameter int unsigned WR_ADDR_W = 10
);
    logic                        pool_start;
    logic                        pool_done;
    logic                        busy;
    logic                        rd_en;
    logic [RD_ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0]    rd_data;
    logic                        wr_en;
    logic [WR_ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0]    wr_data;

    modport master (
        input  pool_start, rd_data,
        output pool_done, busy, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output pool_start, rd_data,
        input  pool_done, busy, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/maxpool_controller.sv
// 2x2 / stride-2 max pooling sequencer over an interleaved conv result RAM.
// Define POOL_RELU_EN to clamp negative pooled results to zero on write.
module maxpool_controller #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MAP_W       = 26,
    parameter int unsigned MAP_H       = 26,
    parameter int unsigned NUM_FILTERS = 4,
    parameter int unsigned RD_ADDR_W   = 12,
    parameter int unsigned WR_ADDR_W   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    maxpool_controller_if.master bus_io
);
    localparam int unsigned PW = MAP_W / 2;
    localparam int unsigned PH = MAP_H / 2;
    localparam int unsigned FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int unsigned CW = (PW > 1) ? $clog2(PW) : 1;
    localparam int unsigned RW = (PH > 1) ? $clog2(PH) : 1;

    typedef enum logic [2:0] {StIdle, StRead, StLast, StWrite, StDone} state_e;

    state_e                   state_q;
    logic [1:0]               k_q;
    logic [FW-1:0]            f_q;
    logic [CW-1:0]            pc_q;
    logic [RW-1:0]            pr_q;
    logic [WR_ADDR_W-1:0]     wcnt_q;
    logic signed [DATA_W-1:0] max_q;

    logic                     pool_done_q;
    logic                     busy_q;
    logic                     rd_en_q;
    logic [RD_ADDR_W-1:0]     rd_addr_q;
    logic                     wr_en_q;
    logic [WR_ADDR_W-1:0]     wr_addr_q;
    logic signed [DATA_W-1:0] wr_data_q;

    logic                     f_last, pc_last, pr_last, out_last;
    logic [FW-1:0]            f_nxt;
    logic [CW-1:0]            pc_nxt;
    logic [RW-1:0]            pr_nxt;
    logic [RD_ADDR_W-1:0]     tl_cur, tl_nxt, rd_addr_nxt;
    logic signed [DATA_W-1:0] max_upd, pooled;

    function automatic logic [RD_ADDR_W-1:0] tl_addr(input int unsigned pr,
                                                    input int unsigned pc,
                                                    input int unsigned f);
        return RD_ADDR_W'((2 * pr * MAP_W + 2 * pc) * NUM_FILTERS + f);
    endfunction

    // Offset of tap k from the top-left tap: TL, TR, BL, BR.
    function automatic logic [RD_ADDR_W-1:0] tap_offset(input logic [1:0] k);
        case (k)
            2'd0:    return '0;
            2'd1:    return RD_ADDR_W'(NUM_FILTERS);
            2'd2:    return RD_ADDR_W'(MAP_W * NUM_FILTERS);
            default: return RD_ADDR_W'((MAP_W + 1) * NUM_FILTERS);
        endcase
    endfunction

    always_comb begin
        f_last   = (f_q == FW'(NUM_FILTERS - 1));
        pc_last  = (pc_q == CW'(PW - 1));
        pr_last  = (pr_q == RW'(PH - 1));
        out_last = f_last && pc_last && pr_last;

        f_nxt  = f_last ? '0 : f_q + FW'(1);
        pc_nxt = pc_q;
        if (f_last) pc_nxt = pc_last ? '0 : pc_q + CW'(1);
        pr_nxt = pr_q;
        if (f_last && pc_last) pr_nxt = pr_last ? '0 : pr_q + RW'(1);

        tl_cur      = tl_addr(32'(pr_q), 32'(pc_q), 32'(f_q));
        tl_nxt      = tl_addr(32'(pr_nxt), 32'(pc_nxt), 32'(f_nxt));
        rd_addr_nxt = tl_cur + tap_offset(k_q + 2'd1);

        // Strict compare so ties keep the value already held.
        max_upd = (bus_io.rd_data > max_q) ? bus_io.rd_data : max_q;
`ifdef POOL_RELU_EN
        pooled = max_upd[DATA_W-1] ? '0 : max_upd;
`else
        pooled = max_upd;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            f_q         <= '0;
            pc_q        <= '0;
            pr_q        <= '0;
            wcnt_q      <= '0;
            max_q       <= '0;
            pool_done_q <= 1'b0;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            pool_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.pool_start) begin
                        state_q   <= StRead;
                        k_q       <= '0;
                        f_q       <= '0;
                        pc_q      <= '0;
                        pr_q      <= '0;
                        wcnt_q    <= '0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                StRead: begin
                    // Read data lags rd_en by one cycle: TL arrives while k=1.
                    if (k_q == 2'd1) begin
                        max_q <= bus_io.rd_data;
                    end else if (k_q != 2'd0) begin
                        max_q <= max_upd;
                    end
                    if (k_q == 2'd3) begin
                        state_q <= StLast;
                        rd_en_q <= 1'b0;
                    end else begin
                        k_q       <= k_q + 2'd1;
                        rd_addr_q <= rd_addr_nxt;
                    end
                end
                StLast: begin
                    state_q   <= StWrite;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= wcnt_q;
                    wr_data_q <= pooled;
                end
                StWrite: begin
                    wr_en_q <= 1'b0;
                    wcnt_q  <= wcnt_q + WR_ADDR_W'(1);
                    if (out_last) begin
                        state_q     <= StDone;
                        pool_done_q <= 1'b1;
                    end else begin
                        state_q   <= StRead;
                        k_q       <= '0;
                        f_q       <= f_nxt;
                        pc_q      <= pc_nxt;
                        pr_q      <= pr_nxt;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= tl_nxt;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.pool_done = pool_done_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.rd_en     = rd_en_q;
    assign bus_io.rd_addr   = rd_addr_q;
    assign bus_io.wr_en     = wr_en_q;
    assign bus_io.wr_addr   = wr_addr_q;
    assign bus_io.wr_data   = wr_data_q;
endmodule

// File: tb/tb_maxpool_controller.sv
// Directed bench: a 4x4x2 instance for data/timing/restart/reset cases and a
// 5x3x1 instance for odd-dimension address coverage.
module tb_maxpool_controller;
    localparam int NA = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_a [8];
    int exp_b_rd [8] = '{0, 1, 5, 6, 2, 3, 7, 8};
    logic signed [15:0] mem_a [32];
    logic signed [15:0] mem_b [16];

    maxpool_controller_if #(.DATA_W(16), .RD_ADDR_W(12), .WR_ADDR_W(10)) a_if ();
    maxpool_controller_if #(.DATA_W(16), .RD_ADDR_W(12), .WR_ADDR_W(10)) b_if ();

    maxpool_controller #(
        .DATA_W(16), .MAP_W(4), .MAP_H(4), .NUM_FILTERS(2), .RD_ADDR_W(12), .WR_ADDR_W(10)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(a_if.master)
    );

    maxpool_controller #(
        .DATA_W(16), .MAP_W(5), .MAP_H(3), .NUM_FILTERS(1), .RD_ADDR_W(12), .WR_ADDR_W(10)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(b_if.master)
    );

    // Conv RAMs: one-cycle read latency.
    always @(posedge clk) begin
        if (a_if.rd_en) a_if.rd_data <= mem_a[a_if.rd_addr[4:0]];
        if (b_if.rd_en) b_if.rd_data <= mem_b[b_if.rd_addr[3:0]];
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pool_done"}, 32'(a_if.pool_done), 0);
        check({tag, " busy"}, 32'(a_if.busy), 0);
        check({tag, " rd_en"}, 32'(a_if.rd_en), 0);
        check({tag, " rd_addr"}, 32'(a_if.rd_addr), 0);
        check({tag, " wr_en"}, 32'(a_if.wr_en), 0);
        check({tag, " wr_addr"}, 32'(a_if.wr_addr), 0);
        check({tag, " wr_data"}, 32'(a_if.wr_data), 0);
    endtask

    // One pass on dut_a, cycle-exact against the spec timeline.
    task automatic run_a(input string tag, input bit repulse, input int abort_at);
        int i, ph, base;
        int offs [4];
        offs[0] = 0; offs[1] = 2; offs[2] = 8; offs[3] = 10;
        @(posedge clk); #1;
        a_if.pool_start = 1'b1;
        for (int c = 1; c <= 6 * NA + 2; c++) begin
            @(posedge clk); #1;
            if (abort_at > 0 && c == abort_at + 1) begin
                check_all_zero($sformatf("%s c%0d", tag, c));
                rst_n = 1'b1;
                break;
            end
            i  = (c - 1) / 6;
            ph = (c - 1) % 6;
            check($sformatf("%s busy c%0d", tag, c), 32'(a_if.busy), (c <= 6 * NA + 1));
            check($sformatf("%s pool_done c%0d", tag, c), 32'(a_if.pool_done),
                  (c == 6 * NA + 1));
            check($sformatf("%s rd_en c%0d", tag, c), 32'(a_if.rd_en), (c <= 6 * NA && ph < 4));
            if (c <= 6 * NA && ph < 4) begin
                base = ((2 * (i / 4)) * 4 + 2 * ((i / 2) % 2)) * 2 + (i % 2);
                check($sformatf("%s rd_addr c%0d", tag, c), 32'(a_if.rd_addr), base + offs[ph]);
            end
            check($sformatf("%s wr_en c%0d", tag, c), 32'(a_if.wr_en), (c <= 6 * NA && ph == 5));
            if (c <= 6 * NA && ph == 5) begin
                check($sformatf("%s wr_addr c%0d", tag, c), 32'(a_if.wr_addr), i);
                check($sformatf("%s wr_data c%0d", tag, c), a_if.wr_data, exp_a[i]);
            end
            a_if.pool_start = repulse && (c == 3 || c == 20);
            if (c == abort_at) rst_n = 1'b0;
        end
        a_if.pool_start = 1'b0;
    endtask

    initial begin
        int i, ph;
        a_if.pool_start = 1'b0;
        b_if.pool_start = 1'b0;
        for (int a = 0; a < 16; a++) mem_b[a] = 16'(a);

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset b busy", 32'(b_if.busy), 0);
        rst_n = 1'b1;

        // Ramp: conv RAM[a] = a
        for (int a = 0; a < 32; a++) mem_a[a] = 16'(a);
        exp_a = '{10, 11, 14, 15, 26, 27, 30, 31};
        run_a("ramp", 1'b0, 0);

        // Start pulses mid-run are ignored
        run_a("repulse", 1'b1, 0);

        // Filter 0 all -5; filter 1 blocks {-7, 3, -1, 2}
        for (int a = 0; a < 32; a++) begin
            if (a % 2 == 0) mem_a[a] = -16'sd5;
            else begin
                unique case ({((a / 2) / 4) % 2, ((a / 2) % 4) % 2})
                    2'b00: mem_a[a] = -16'sd7;
                    2'b01: mem_a[a] = 16'sd3;
                    2'b10: mem_a[a] = -16'sd1;
                    default: mem_a[a] = 16'sd2;
                endcase
            end
        end
`ifdef POOL_RELU_EN
        exp_a = '{0, 3, 0, 3, 0, 3, 0, 3};
`else
        exp_a = '{-5, 3, -5, 3, -5, 3, -5, 3};
`endif
        run_a("mixed", 1'b0, 0);

        // Ties and extremes
        for (int a = 0; a < 32; a++) mem_a[a] = '0;
        mem_a[0] = 16'sh7FFF; mem_a[2] = 16'sh7FFF; mem_a[8] = 16'sh7FFF; mem_a[10] = 16'sh7FFF;
        mem_a[1] = -16'sd32768; mem_a[3] = -16'sd1; mem_a[9] = -16'sd1; mem_a[11] = -16'sd1;
`ifdef POOL_RELU_EN
        exp_a = '{32767, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_a = '{32767, -1, 0, 0, 0, 0, 0, 0};
`endif
        run_a("tie", 1'b0, 0);

        // Reset at cycle 15 of a run, then a clean pass
        for (int a = 0; a < 32; a++) mem_a[a] = 16'(a);
        exp_a = '{10, 11, 14, 15, 26, 27, 30, 31};
        run_a("abort", 1'b0, 15);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("post-abort pool_done %0d", c), 32'(a_if.pool_done), 0);
            check($sformatf("post-abort busy %0d", c), 32'(a_if.busy), 0);
        end
        run_a("after_abort", 1'b0, 0);

        // Odd dimensions: 5x3x1
        @(posedge clk); #1;
        b_if.pool_start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            b_if.pool_start = 1'b0;
            i  = (c - 1) / 6;
            ph = (c - 1) % 6;
            check($sformatf("odd rd_en c%0d", c), 32'(b_if.rd_en), (c <= 12 && ph < 4));
            if (c <= 12 && ph < 4)
                check($sformatf("odd rd_addr c%0d", c), 32'(b_if.rd_addr), exp_b_rd[i * 4 + ph]);
            check($sformatf("odd wr_en c%0d", c), 32'(b_if.wr_en), (c <= 12 && ph == 5));
            if (c <= 12 && ph == 5) begin
                check($sformatf("odd wr_addr c%0d", c), 32'(b_if.wr_addr), i);
                check($sformatf("odd wr_data c%0d", c), b_if.wr_data, (i == 0) ? 6 : 8);
            end
            check($sformatf("odd pool_done c%0d", c), 32'(b_if.pool_done), (c == 13));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/maxpool_controller.md
# maxpool_controller

Sequences 2x2/stride-2 max pooling over the convolution result RAM once the top-level controller has finished all windows and filters. It starts on `pool_start`, issues reads to the conv result RAM, and reduces each 2x2 neighbourhood per filter. Each result is written to the pooled feature RAM, and a single-cycle `pool_done` is returned to the top-level controller.

## Interface
- DATA_W, 16: signed width of conv results and pooled outputs
- MAP_W, 26: conv output map width (columns)
- MAP_H, 26: conv output map height (rows)
- NUM_FILTERS, 4: filters interleaved per map position
- RD_ADDR_W, 12: conv RAM address width; must hold MAP_W*MAP_H*NUM_FILTERS
- WR_ADDR_W, 10: pool RAM address width; must hold (MAP_W/2)*(MAP_H/2)*NUM_FILTERS
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- pool_start  in  1  start pulse; sampled only in IDLE
- pool_done  out  1  one-cycle pulse after the last write
- busy  out  1  high from the first READ cycle through the pool_done cycle inclusive
- rd_en  out  1  conv RAM read strobe
- rd_addr  out  RD_ADDR_W  conv RAM read address
- rd_data  in  DATA_W  conv RAM data, valid exactly 1 cycle after rd_en
- wr_en  out  1  pool RAM write strobe
- wr_addr  out  WR_ADDR_W  pool RAM write address
- wr_data  out  DATA_W  pooled value

## Operation
- Conv RAM layout: addr = (row*MAP_W + col)*NUM_FILTERS + f.
- Pool RAM layout: addr = (pr*PW + pc)*NUM_FILTERS + f.
- PW = floor(MAP_W/2) and PH = floor(MAP_H/2). With odd dimensions, the last column and row are never read.
- Iteration order: f is innermost, then pc, then pr. The total number of outputs is N = PH*PW*NUM_FILTERS.
- Per output, base = ((2pr)*MAP_W + 2pc)*NUM_FILTERS + f. The four reads are issued in order TL = base, TR = base+NUM_FILTERS, BL = base+MAP_W*NUM_FILTERS, BR = BL+NUM_FILTERS.
- FSM states and transitions:
  - IDLE: on pool_start, go to READ with k=0 and all counters cleared.
  - READ: lasts 4 cycles (k=0..3). rd_en=1 and rd_addr = TL/TR/BL/BR for k=0/1/2/3. After k=3, go to LAST.
  - LAST: lasts 1 cycle. rd_en=0 and the BR data is captured. Go to WRITE.
  - WRITE: lasts 1 cycle. wr_en=1 with the current wr_addr and wr_data. If this is the final output, go to DONE; otherwise advance the counters and go to READ.
  - DONE: lasts 1 cycle. pool_done=1, then go to IDLE.
- Reduction: a running max register is loaded with the TL data, then updated with a signed compare for TR, BL and BR. Ties keep the existing value.
- Counters f, pc and pr wrap to 0 at NUM_FILTERS, PW and PH. The wr_addr counter increments by 1 after each write, giving a sequential 0..N-1 write order.
- pool_start is ignored while in any non-IDLE state; it is neither queued nor used to restart.
- Reset (including mid-operation): state returns to IDLE and counters clear. All outputs go to 0: pool_done, busy, rd_en, rd_addr, wr_en, wr_addr, wr_data. No pool_done is emitted for an aborted run.
- rd_addr, wr_addr and wr_data hold their last values when not strobed. They are meaningful only when their strobe is high.

## Timing
- Cycle 0: pool_start is sampled high in IDLE.
- Cycle 1: first READ cycle; busy rises.
- Each output occupies exactly 6 cycles: READ x4, LAST, WRITE.
- Output i (0-based) has its wr_en at cycle 6i+6.
- pool_done is high at cycle 6N+1. busy falls at cycle 6N+2, when the block is back in IDLE and able to accept a new start.
- rd_en is never high in the same cycle as wr_en.
- No back-to-back restart: the earliest next start is sampled at cycle 6N+2.

## Configuration
- POOL_RELU_EN defined: wr_data = max(pooled max, 0), so negative results are written as 0.
- POOL_RELU_EN undefined: wr_data = the raw signed max.
- Cycle timing is identical in both builds.

## Test plan
- MAP_W=MAP_H=4, NUM_FILTERS=2, conv RAM[a]=a, pool_start at cycle 0 -> 8 writes at wr_addr 0..7 with wr_data 10,11,14,15,26,27,30,31; pool_done at cycle 49 only.
- Same dims, filter 0 map all -5, filter 1 map mixed {-7,3,-1,2} per block -> with POOL_RELU_EN: f0 writes 0 and f1 writes 3. Without it: f0 writes -5 and f1 writes 3.
- MAP_W=5, MAP_H=3, NUM_FILTERS=1 -> N=2; rd_addr sequence 0,1,5,6 then 2,3,7,8. Column 4 and row 2 are never read.
- pool_start re-pulsed at cycles 3 and 20 during a run -> no change to the address sequence; exactly one pool_done.
- rst_n low at cycle 15 of a run -> all outputs 0 on the next cycle; no pool_done. A subsequent pool_start runs a full, correct pass from wr_addr 0.
- Tie case: all four values equal 0x7FFF, and a block with TL=-32768 and the others -1 -> writes 0x7FFF and -1 (raw build).
